hist_bin_counter: RTL and testbench
===================================

// Module: hist_bin_counter
// PURPOSE
//  Builds a per-frame histogram of an incoming pixel stream in an on-chip bin RAM.
//  Sits directly upstream of the histogram accumulator (CDF stage).
//  On frame_end it sweeps all bins in order and streams each count out as (bin_data, bin_valid),
//  zeroing every bin as it is read. It pulses acc_clear one cycle before the sweep so the
//  downstream accumulator restarts from 0.
// PARAMETERS
//  PIXEL_WIDTH  8   pixel bits; NBINS = 2**PIXEL_WIDTH
//  COUNT_WIDTH  14  bits per bin count; equals the downstream accumulator DATA_WIDTH
// PORTS
//  clk          in   1            clock, all logic on rising edge
//  arstn        in   1            asynchronous active-low reset
//  pix_in       in   PIXEL_WIDTH  pixel value = bin index
//  pix_valid    in   1            pix_in qualifier
//  frame_end    in   1            1-cycle pulse: frame complete, start readout
//  busy         out  1            high in INIT/DRAIN/CLR/READOUT; pixels not counted
//  pix_drop     out  1            sticky: pix_valid seen while busy; cleared only by reset
//  acc_clear    out  1            1-cycle pulse; drives accumulator clear
//  bin_data     out  COUNT_WIDTH  bin count; drives accumulator data_in
//  bin_valid    out  1            drives accumulator data_valid
//  bin_index    out  PIXEL_WIDTH  index of bin on bin_data
//  bin_last     out  1            high with bin_valid for bin NBINS-1
// BEHAVIOUR
//  - Reset: all outputs 0 except busy = 1; state = INIT. RAM contents are not reset.
//  - Bin RAM: NBINS x COUNT_WIDTH, single write port, synchronous read with 1-cycle latency.
//  - FSM:
//      INIT    -> COUNT    after writing 0 to bins 0..NBINS-1 (one per cycle, NBINS cycles).
//      COUNT   -> DRAIN    on frame_end.
//      DRAIN   -> CLR      after 2 cycles, so all pending increments are committed.
//      CLR     -> READOUT  after 1 cycle; acc_clear = 1 in the CLR cycle only.
//      READOUT -> COUNT    after the cycle that presents bin NBINS-1.
//    busy = 0 only in COUNT.
//  - Counting (COUNT state), 2-stage read-modify-write:
//      Cycle t:   read address = pix_in.
//      Cycle t+1: operand selected, operand + 1 written to the same bin.
//      Operand priority:
//        (a) value being written this cycle, if it targets the same bin (back-to-back hit);
//        (b) value written in cycle t, if it targets the same bin (1-gap hit);
//        (c) RAM read data otherwise.
//      Every valid pixel counts exactly once, with no stall, for any bin sequence.
//  - frame_end coincident with pix_valid: that pixel is counted.
//  - pix_valid while busy: pixel ignored and pix_drop set.
//  - frame_end while busy: ignored.
//  - READOUT:
//      Bin k is read in cycle s+k.
//      In cycle s+k+1: bin_valid = 1, bin_index = k, bin_data = count, and 0 is written to bin k.
//      bin_valid stays high for exactly NBINS consecutive cycles.
//      bin_last is high with bin k = NBINS-1.
//      No backpressure; the consumer must accept every cycle.
//  - Latency: frame_end in cycle f
//      -> acc_clear at f+3
//      -> first bin_valid at f+5
//      -> bin_last at f+4+NBINS
//      -> busy low at f+5+NBINS.
//  - Wrap-around: a count of 2**COUNT_WIDTH-1 plus 1 wraps to 0 (default build).
//  - Reset mid-operation: FSM returns to INIT, bin_valid drops immediately, and the full
//    zeroing sweep reruns.
// CONFIGURATION
//  HIST_SATURATE_EN
//    Defined:   an increment at 2**COUNT_WIDTH-1 holds at 2**COUNT_WIDTH-1 (saturates).
//    Undefined: modulo 2**COUNT_WIDTH wrap.
//  No other behavioural difference between the two builds.
// TESTING
//  1. Release reset
//       -> busy = 1 for NBINS cycles of INIT (256 at defaults), then 0.
//       -> An immediate frame_end reads out 256 zero bins.
//  2. Ten back-to-back pixels of 5, then frame_end
//       -> bin 5 = 10, all other bins = 0.
//       -> acc_clear at f+3; bin_last with bin_index = 255.
//  3. Sequence 3,3,idle,3,7,idle,idle,3 (exercises all forwarding paths)
//       -> bin 3 = 4, bin 7 = 1.
//  4. pix_valid = 1 with pix_in = 9 during READOUT
//       -> pix_drop = 1; bin 9 = 0 in the next frame's readout.
//  5. COUNT_WIDTH = 4, twenty pixels of 2
//       -> bin 2 = 4 (wrap) without HIST_SATURATE_EN; 15 with HIST_SATURATE_EN.
//  6. Two consecutive frames: 4 pixels of 1, then 2 pixels of 1
//       -> second readout shows bin 1 = 2 (bins cleared by readout).

Source files
------------

// File: rtl/hist_bin_counter_if.sv
// Pixel-in / bin-out signal bundle for hist_bin_counter.
// The slave modport is the counter itself; master is the pixel source plus bin consumer.
interface hist_bin_counter_if #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH = 14
);
  logic [PIXEL_WIDTH-1:0] pix_in;
  logic                   pix_valid;
  logic                   frame_end;
  logic                   busy;
  logic                   pix_drop;
  logic                   acc_clear;
  logic [COUNT_WIDTH-1:0] bin_data;
  logic                   bin_valid;
  logic [PIXEL_WIDTH-1:0] bin_index;
  logic                   bin_last;

  modport master (
    output pix_in, pix_valid, frame_end,
    input  busy, pix_drop, acc_clear, bin_data, bin_valid, bin_index, bin_last
  );

  modport slave (
    input  pix_in, pix_valid, frame_end,
    output busy, pix_drop, acc_clear, bin_data, bin_valid, bin_index, bin_last
  );
endinterface

// File: rtl/hist_bin_counter.sv
// Per-frame pixel histogram in a bin RAM, swept out (and zeroed) on frame_end.
// Define HIST_SATURATE_EN to make bin counts saturate instead of wrapping.
module hist_bin_counter #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH = 14
) (
  input logic         clk,
  input logic         arstn,
  hist_bin_counter_if.slave hist
);

  localparam int unsigned NBINS = 2 ** PIXEL_WIDTH;
  localparam logic [PIXEL_WIDTH:0] LastBin = (PIXEL_WIDTH + 1)'(NBINS - 1);

  typedef logic [PIXEL_WIDTH-1:0] idx_t;
  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  typedef enum logic [2:0] {
    StInit,
    StCount,
    StDrain,
    StClr,
    StReadout
  } state_e;

  state_e               state_q, state_d;
  logic [PIXEL_WIDTH:0] seq_q, seq_d;
  logic                 drain_q, drain_d;

  // Counting pipeline: read stage, then the write currently on the port, then the one before it.
  logic rd_v_q, wr_v_q, wr2_v_q;
  idx_t rd_idx_q, wr_idx_q, wr2_idx_q;
  cnt_t wr_data_q, wr2_data_q;

  logic ro_v_q;
  idx_t ro_idx_q;
  logic drop_q;

  cnt_t mem [NBINS];
  cnt_t ram_rdata;
  idx_t ram_raddr;
  logic ram_we;
  idx_t ram_waddr;
  cnt_t ram_wdata;

  logic busy;
  logic issue_pix, issue_ro;
  cnt_t operand, incr;

  assign busy      = (state_q != StCount);
  assign issue_pix = (state_q == StCount) && hist.pix_valid;
  assign issue_ro  = (state_q == StReadout) && !seq_q[PIXEL_WIDTH];
  assign ram_raddr = (state_q == StReadout) ? seq_q[PIXEL_WIDTH-1:0] : hist.pix_in;

  // The RAM returns pre-write data for the two most recent writes, so forward them.
  always_comb begin
    operand = ram_rdata;
    if (wr_v_q && (wr_idx_q == rd_idx_q)) begin
      operand = wr_data_q;
    end else if (wr2_v_q && (wr2_idx_q == rd_idx_q)) begin
      operand = wr2_data_q;
    end
  end

`ifdef HIST_SATURATE_EN
  assign incr = (operand == '1) ? operand : operand + cnt_t'(1);
`else
  assign incr = operand + cnt_t'(1);
`endif

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (state_q == StInit) begin
      ram_we    = 1'b1;
      ram_waddr = seq_q[PIXEL_WIDTH-1:0];
    end else if (wr_v_q) begin
      ram_we    = 1'b1;
      ram_waddr = wr_idx_q;
      ram_wdata = wr_data_q;
    end else if (ro_v_q) begin
      ram_we    = 1'b1;
      ram_waddr = ro_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_raddr];
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    drain_d = drain_q;
    unique case (state_q)
      StInit: begin
        seq_d = seq_q + 1'b1;
        if (seq_q == LastBin) begin
          state_d = StCount;
          seq_d   = '0;
        end
      end
      StCount: begin
        if (hist.frame_end) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = StClr;
        end
      end
      StClr: begin
        state_d = StReadout;
        seq_d   = '0;
      end
      StReadout: begin
        seq_d = seq_q + 1'b1;
        // seq_q == NBINS is the cycle presenting the last bin; no read is issued.
        if (seq_q[PIXEL_WIDTH]) begin
          state_d = StCount;
          seq_d   = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= StInit;
      seq_q      <= '0;
      drain_q    <= 1'b0;
      rd_v_q     <= 1'b0;
      rd_idx_q   <= '0;
      wr_v_q     <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      wr2_v_q    <= 1'b0;
      wr2_idx_q  <= '0;
      wr2_data_q <= '0;
      ro_v_q     <= 1'b0;
      ro_idx_q   <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      drain_q    <= drain_d;
      rd_v_q     <= issue_pix;
      rd_idx_q   <= hist.pix_in;
      wr_v_q     <= rd_v_q;
      wr_idx_q   <= rd_idx_q;
      wr_data_q  <= incr;
      wr2_v_q    <= wr_v_q;
      wr2_idx_q  <= wr_idx_q;
      wr2_data_q <= wr_data_q;
      ro_v_q     <= issue_ro;
      ro_idx_q   <= seq_q[PIXEL_WIDTH-1:0];
      drop_q     <= drop_q | (hist.pix_valid & busy);
    end
  end

  assign hist.busy      = busy;
  assign hist.pix_drop  = drop_q;
  assign hist.acc_clear = (state_q == StClr);
  assign hist.bin_valid = ro_v_q;
  assign hist.bin_index = ro_v_q ? ro_idx_q : '0;
  assign hist.bin_data  = ro_v_q ? ram_rdata : '0;
  assign hist.bin_last  = ro_v_q && (ro_idx_q == '1);

endmodule

// File: tb/tb_hist_bin_counter.sv
// Directed bench for hist_bin_counter: a default-size instance plus a 3-bit/4-bit one for
// the wrap/saturate case. Expected histograms are written out by hand per scenario.
module tb_hist_bin_counter;

  logic clk;
  logic arstn;
  int   checks;
  int   errors;

  hist_bin_counter_if #(.PIXEL_WIDTH(8), .COUNT_WIDTH(14)) m ();
  hist_bin_counter_if #(.PIXEL_WIDTH(3), .COUNT_WIDTH(4))  s ();

  hist_bin_counter #(.PIXEL_WIDTH(8), .COUNT_WIDTH(14)) u_dut (
    .clk  (clk),
    .arstn(arstn),
    .hist (m)
  );

  hist_bin_counter #(.PIXEL_WIDTH(3), .COUNT_WIDTH(4)) u_small (
    .clk  (clk),
    .arstn(arstn),
    .hist (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] got [256];
  logic [13:0] exp_bins [256];
  int clr_cyc, nclr, first_cyc, last_cyc, last_idx, busy_cyc, nvalid, order_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void clear_exp();
    for (int k = 0; k < 256; k++) exp_bins[k] = '0;
  endfunction

  task automatic drive_pix(input int p);
    if (p < 0) begin
      m.pix_valid = 1'b0;
    end else begin
      m.pix_valid = 1'b1;
      m.pix_in    = 8'(p);
    end
    step();
    m.pix_valid = 1'b0;
  endtask

  // Pulses frame_end in the current cycle and records the readout; cycles counted from f.
  task automatic run_frame(input bit coin, input int coin_pix, input bit disturb);
    for (int k = 0; k < 256; k++) got[k] = 'x;
    clr_cyc = -1; nclr = 0; first_cyc = -1; last_cyc = -1; last_idx = -1;
    busy_cyc = -1; nvalid = 0; order_err = 0;
    m.frame_end = 1'b1;
    if (coin) begin
      m.pix_valid = 1'b1;
      m.pix_in    = 8'(coin_pix);
    end
    for (int cyc = 1; cyc <= 600 && busy_cyc < 0; cyc++) begin
      step();
      m.frame_end = 1'b0;
      m.pix_valid = 1'b0;
      if (disturb && cyc == 10) begin
        m.pix_valid = 1'b1;
        m.pix_in    = 8'd9;
      end
      if (disturb && cyc == 20) m.frame_end = 1'b1;
      if (m.acc_clear) begin
        if (clr_cyc < 0) clr_cyc = cyc;
        nclr++;
      end
      if (m.bin_valid) begin
        if (m.bin_index !== 8'(nvalid)) order_err++;
        got[m.bin_index] = m.bin_data;
        if (first_cyc < 0) first_cyc = cyc;
        nvalid++;
        if (m.bin_last) begin
          last_cyc = cyc;
          last_idx = int'(m.bin_index);
        end
      end
      if (!m.busy) busy_cyc = cyc;
    end
    if (busy_cyc < 0) begin
      errors++;
      $display("FAIL frame_timeout: busy never dropped within 600 cycles");
    end
  endtask

  task automatic test_reset();
    int n;
    arstn = 1'b0;
    m.pix_in = '0; m.pix_valid = 1'b0; m.frame_end = 1'b0;
    s.pix_in = '0; s.pix_valid = 1'b0; s.frame_end = 1'b0;
    step();
    step();
    checks++;
    if (m.busy !== 1'b1 || m.bin_valid !== 1'b0 || m.acc_clear !== 1'b0 || m.pix_drop !== 1'b0 ||
        m.bin_data !== 14'd0 || m.bin_last !== 1'b0 || m.bin_index !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b valid=%b clr=%b drop=%b data=%0d last=%b idx=%0d, need 1 0 0 0 0 0 0",
               m.busy, m.bin_valid, m.acc_clear, m.pix_drop, m.bin_data, m.bin_last, m.bin_index);
    end
    arstn = 1'b1;
    n = 0;
    while (m.busy && n < 400) begin
      n++;
      step();
    end
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL init_busy_cycles: got %0d, need 256", n);
    end
    clear_exp();
    run_frame(1'b0, 0, 1'b0);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (got[k] !== exp_bins[k]) begin
        errors++;
        $display("FAIL init_zero_bin%0d: got %0d, need %0d", k, got[k], exp_bins[k]);
      end
    end
    checks++;
    if (clr_cyc !== 3 || nclr !== 1 || first_cyc !== 5 || last_cyc !== 260 || busy_cyc !== 261) begin
      errors++;
      $display("FAIL init_latency: clr=%0d x%0d first=%0d last=%0d idle=%0d, need 3 x1 5 260 261",
               clr_cyc, nclr, first_cyc, last_cyc, busy_cyc);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) drive_pix(5);
    clear_exp();
    exp_bins[5] = 14'd10;
    run_frame(1'b0, 0, 1'b0);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (got[k] !== exp_bins[k]) begin
        errors++;
        $display("FAIL b2b_bin%0d: got %0d, need %0d", k, got[k], exp_bins[k]);
      end
    end
    checks++;
    if (clr_cyc !== 3 || nvalid !== 256 || order_err !== 0 || last_idx !== 255 ||
        last_cyc !== 260 || busy_cyc !== 261 || first_cyc !== 5) begin
      errors++;
      $display("FAIL b2b_readout: clr=%0d n=%0d order_err=%0d last_idx=%0d last=%0d idle=%0d first=%0d, need 3 256 0 255 260 261 5",
               clr_cyc, nvalid, order_err, last_idx, last_cyc, busy_cyc, first_cyc);
    end
  endtask

  task automatic test_forwarding();
    int seq [8] = '{3, 3, -1, 3, 7, -1, -1, 3};
    for (int i = 0; i < 8; i++) drive_pix(seq[i]);
    clear_exp();
    exp_bins[3] = 14'd4;
    exp_bins[7] = 14'd1;
    exp_bins[4] = 14'd1;
    // Pixel 4 arrives together with frame_end and must still be counted.
    run_frame(1'b1, 4, 1'b0);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (got[k] !== exp_bins[k]) begin
        errors++;
        $display("FAIL fwd_bin%0d: got %0d, need %0d", k, got[k], exp_bins[k]);
      end
    end
  endtask

  task automatic test_drop();
    checks++;
    if (m.pix_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_before: got %b, need 0", m.pix_drop);
    end
    clear_exp();
    run_frame(1'b0, 0, 1'b1);
    checks++;
    if (m.pix_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_set: got %b, need 1", m.pix_drop);
    end
    checks++;
    if (nvalid !== 256 || busy_cyc !== 261 || nclr !== 1) begin
      errors++;
      $display("FAIL busy_frame_end_ignored: n=%0d idle=%0d clr=%0d, need 256 261 1",
               nvalid, busy_cyc, nclr);
    end
    run_frame(1'b0, 0, 1'b0);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (got[k] !== exp_bins[k]) begin
        errors++;
        $display("FAIL drop_next_bin%0d: got %0d, need %0d", k, got[k], exp_bins[k]);
      end
    end
    checks++;
    if (m.pix_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_sticky: got %b, need 1", m.pix_drop);
    end
  endtask

  task automatic test_two_frames();
    for (int i = 0; i < 4; i++) drive_pix(1);
    run_frame(1'b0, 0, 1'b0);
    checks++;
    if (got[1] !== 14'd4 || got[0] !== 14'd0 || got[2] !== 14'd0) begin
      errors++;
      $display("FAIL frame1_bin1: got b0=%0d b1=%0d b2=%0d, need 0 4 0", got[0], got[1], got[2]);
    end
    for (int i = 0; i < 2; i++) drive_pix(1);
    run_frame(1'b0, 0, 1'b0);
    checks++;
    if (got[1] !== 14'd2 || got[0] !== 14'd0 || got[2] !== 14'd0) begin
      errors++;
      $display("FAIL frame2_bin1: got b0=%0d b1=%0d b2=%0d, need 0 2 0", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] sgot [8];
    logic [3:0] want;
    int sn, slast;
`ifdef HIST_SATURATE_EN
    want = 4'd15;
`else
    want = 4'd4;
`endif
    for (int k = 0; k < 8; k++) sgot[k] = 'x;
    sn = 0;
    slast = -1;
    for (int i = 0; i < 20; i++) begin
      s.pix_valid = 1'b1;
      s.pix_in    = 3'd2;
      step();
    end
    s.pix_valid = 1'b0;
    s.frame_end = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      s.frame_end = 1'b0;
      if (s.bin_valid) begin
        sgot[s.bin_index] = s.bin_data;
        sn++;
        if (s.bin_last) slast = int'(s.bin_index);
      end
    end
    checks++;
    if (sgot[2] !== want) begin
      errors++;
      $display("FAIL wrap_bin2: got %0d, need %0d", sgot[2], want);
    end
    checks++;
    if (sgot[0] !== 4'd0 || sgot[7] !== 4'd0 || sn !== 8 || slast !== 7) begin
      errors++;
      $display("FAIL wrap_readout: b0=%0d b7=%0d n=%0d last=%0d, need 0 0 8 7",
               sgot[0], sgot[7], sn, slast);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    m.frame_end = 1'b1;
    step();
    m.frame_end = 1'b0;
    for (int i = 0; i < 49; i++) step();
    checks++;
    if (m.bin_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_readout_active: got valid=%b, need 1", m.bin_valid);
    end
    arstn = 1'b0;
    #1;
    checks++;
    if (m.bin_valid !== 1'b0 || m.busy !== 1'b1 || m.pix_drop !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: valid=%b busy=%b drop=%b, need 0 1 0",
               m.bin_valid, m.busy, m.pix_drop);
    end
    step();
    arstn = 1'b1;
    n = 0;
    while (m.busy && n < 400) begin
      n++;
      step();
    end
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL mid_reinit_cycles: got %0d, need 256", n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_back_to_back();
    test_forwarding();
    test_drop();
    test_two_frames();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
